// File: rtl/reset_sequencer_if.sv
// Reset sequencer signal bundle: lock/request inputs and staged reset outputs.
// The master side is the sequencer itself; the slave side is the clock/CPU/consumer side.
interface reset_sequencer_if;
  logic       clk_locked;
  logic       sysresetreq;
  logic       bus_reset_n;
  logic       periph_reset_n;
  logic       cpu_reset_n;
  logic       seq_done;
  logic [1:0] reset_cause;

  modport master (
    input  clk_locked,
    input  sysresetreq,
    output bus_reset_n,
    output periph_reset_n,
    output cpu_reset_n,
    output seq_done,
    output reset_cause
  );

  modport slave (
    output clk_locked,
    output sysresetreq,
    input  bus_reset_n,
    input  periph_reset_n,
    input  cpu_reset_n,
    input  seq_done,
    input  reset_cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: qualifies MMCM lock, then releases bus, peripheral and CPU resets in order.
// A CPU system reset request re-runs the peripheral and CPU stages while the bus stays out of reset.

// Invariant checker for the reset outputs; instantiated by the sequencer.
module reset_sequencer_checker (
  input logic hclk,
  input logic bus_reset_n,
  input logic periph_reset_n,
  input logic cpu_reset_n,
  input logic seq_done
);
  // Release ordering must hold on every cycle.
  a_cpu_after_periph : assert property (@(posedge hclk) cpu_reset_n |-> periph_reset_n);
  a_periph_after_bus : assert property (@(posedge hclk) periph_reset_n |-> bus_reset_n);
  a_done_in_run      : assert property (@(posedge hclk) seq_done |-> cpu_reset_n);
endmodule

module reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_DELAY        = 16,
  parameter int unsigned CNT_W              = 16
) (
  input  logic                hclk,
  input  logic                ext_reset_n,
  reset_sequencer_if.master   rs
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK  = 3'd0,
    S_STG_BUS    = 3'd1,
    S_STG_PERIPH = 3'd2,
    S_RUN        = 3'd3,
    S_SW_HOLD    = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_EXT  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Released-reset pattern {cpu, periph, bus} for each state.
  function automatic logic [2:0] release_vec(input state_e s);
    logic [2:0] v;
    case (s)
      S_STG_BUS:    v = 3'b001;
      S_STG_PERIPH: v = 3'b011;
      S_RUN:        v = 3'b111;
      S_SW_HOLD:    v = 3'b001;
      default:      v = 3'b000;
    endcase
    return v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_cmp_s, cnt_inc_s;
  logic             cnt_last_s;
  logic             sync1_q, lock_s_q;
  logic             bus_q, periph_q, cpu_q, done_q;
  logic [1:0]       cause_q, cause_d;
  logic [2:0]       rel_d;

  // Two-flop synchroniser for the asynchronous MMCM lock.
  always_ff @(posedge hclk) begin
    if (!ext_reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= rs.clk_locked;
      lock_s_q <= sync1_q;
    end
  end

  // Shared delay counter: compare value depends on state; increment saturates at it.
  always_comb begin
    cnt_cmp_s = STAGE_LAST;
    case (state_q)
      S_WAIT_LOCK: cnt_cmp_s = LOCK_LAST;
      default:     cnt_cmp_s = STAGE_LAST;
    endcase
    cnt_last_s = (cnt_q == cnt_cmp_s);
    if (cnt_last_s) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // Next-state logic; lock loss outranks both sysresetreq and counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if ((state_q != S_WAIT_LOCK) && !lock_s_q) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = CNT_ZERO;
      cause_d = CAUSE_LOCK;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (!lock_s_q) begin
            cnt_d = CNT_ZERO;
          end else if (cnt_last_s) begin
            state_d = S_STG_BUS;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_STG_BUS: begin
          if (cnt_last_s) begin
            state_d = S_STG_PERIPH;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_STG_PERIPH: begin
          if (cnt_last_s) begin
            state_d = S_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_RUN: begin
          if (rs.sysresetreq) begin
            state_d = S_SW_HOLD;
            cnt_d   = CNT_ZERO;
            cause_d = CAUSE_SW;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        S_SW_HOLD: begin
          // Leaves after exactly STAGE_DELAY cycles regardless of sysresetreq.
          if (cnt_last_s) begin
            state_d = S_STG_PERIPH;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
    rel_d = release_vec(state_d);
  end

  // State, counter and outputs update together; outputs reflect the state being entered.
  always_ff @(posedge hclk) begin
    if (!ext_reset_n) begin
      state_q  <= S_WAIT_LOCK;
      cnt_q    <= CNT_ZERO;
      bus_q    <= 1'b0;
      periph_q <= 1'b0;
      cpu_q    <= 1'b0;
      done_q   <= 1'b0;
      cause_q  <= CAUSE_EXT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bus_q    <= rel_d[0];
      periph_q <= rel_d[1];
      cpu_q    <= rel_d[2];
      done_q   <= (state_d == S_RUN);
      cause_q  <= cause_d;
    end
  end

  assign rs.bus_reset_n    = bus_q;
  assign rs.periph_reset_n = periph_q;
  assign rs.cpu_reset_n    = cpu_q;
  assign rs.seq_done       = done_q;
  assign rs.reset_cause    = cause_q;

  reset_sequencer_checker u_chk (
    .hclk           (hclk),
    .bus_reset_n    (bus_q),
    .periph_reset_n (periph_q),
    .cpu_reset_n    (cpu_q),
    .seq_done       (done_q)
  );

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK_STABLE_CYCLES=8, STAGE_DELAY=4.
// Observed vector is {bus, periph, cpu, seq_done, reset_cause[1:0]}; edge 0 is the first release edge.
module tb_reset_sequencer;

  logic hclk;
  logic ext_reset_n;
  int   n_checks;
  int   n_fail;

  reset_sequencer_if rs_if ();

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .STAGE_DELAY        (4),
    .CNT_W              (8)
  ) dut (
    .hclk        (hclk),
    .ext_reset_n (ext_reset_n),
    .rs          (rs_if.master)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic logic [5:0] obs_vec();
    return {rs_if.bus_reset_n, rs_if.periph_reset_n, rs_if.cpu_reset_n,
            rs_if.seq_done, rs_if.reset_cause};
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic apply_reset();
    ext_reset_n       = 1'b0;
    rs_if.clk_locked  = 1'b0;
    rs_if.sysresetreq = 1'b0;
    repeat (2) tick();
  endtask

  // Reset, release with lock high, run edges 0..17 so the sequencer ends in RUN.
  task automatic bring_up();
    apply_reset();
    ext_reset_n      = 1'b1;
    rs_if.clk_locked = 1'b1;
    repeat (18) tick();
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    ext_reset_n       = 1'b0;
    rs_if.clk_locked  = 1'b1;
    rs_if.sysresetreq = 1'b1;
    repeat (3) tick();
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected %b", obs, 6'b000000);
    end
    rs_if.sysresetreq = 1'b0;
  endtask

  task automatic test_power_up();
    logic [5:0] obs, exp;
    apply_reset();
    ext_reset_n      = 1'b1;
    rs_if.clk_locked = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      obs = obs_vec();
      exp = {e >= 9, e >= 13, e >= 17, e >= 17, 2'd0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL power_up edge %0d: got %b expected %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_lock_glitch();
    logic [5:0] obs, exp;
    apply_reset();
    ext_reset_n = 1'b1;
    for (int e = 0; e <= 16; e++) begin
      rs_if.clk_locked = (e != 5);
      tick();
      obs = obs_vec();
      exp = {e >= 15, 5'b00000};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL lock_glitch edge %0d: got %b expected %b", e, obs, exp);
      end
    end
    rs_if.clk_locked = 1'b1;
  endtask

  task automatic test_sw_pulse();
    logic [5:0] obs, exp;
    bring_up();
    rs_if.sysresetreq = 1'b1;
    tick();
    rs_if.sysresetreq = 1'b0;
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b100010) begin
      n_fail++;
      $display("FAIL sw_pulse entry: got %b expected %b", obs, 6'b100010);
    end
    for (int i = 1; i <= 9; i++) begin
      tick();
      obs = obs_vec();
      exp = {1'b1, i >= 4, i >= 8, i >= 8, 2'd2};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL sw_pulse step %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_sw_held();
    logic [5:0] obs, exp;
    bring_up();
    rs_if.sysresetreq = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) begin
      tick();
      obs = obs_vec();
      if (i == 9)
        exp = 6'b100010;
      else
        exp = {1'b1, i >= 4, i >= 8, i >= 8, 2'd2};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL sw_held step %0d: got %b expected %b", i, obs, exp);
      end
    end
    rs_if.sysresetreq = 1'b0;
  endtask

  task automatic test_lock_loss_periph();
    logic [5:0] obs, exp;
    apply_reset();
    ext_reset_n      = 1'b1;
    rs_if.clk_locked = 1'b1;
    repeat (14) tick();
    rs_if.clk_locked = 1'b0;
    tick();
    tick();
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b110000) begin
      n_fail++;
      $display("FAIL lock_loss_sync_latency: got %b expected %b", obs, 6'b110000);
    end
    tick();
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b000001) begin
      n_fail++;
      $display("FAIL lock_loss_assert: got %b expected %b", obs, 6'b000001);
    end
    rs_if.clk_locked = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      tick();
      obs = obs_vec();
      exp = {e >= 9, e >= 13, e >= 17, e >= 17, 2'd1};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL relock edge %0d: got %b expected %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_lock_loss_expiry();
    logic [5:0] obs;
    apply_reset();
    ext_reset_n      = 1'b1;
    rs_if.clk_locked = 1'b1;
    repeat (15) tick();
    rs_if.clk_locked = 1'b0;
    tick();
    tick();
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b110000) begin
      n_fail++;
      $display("FAIL expiry_before: got %b expected %b", obs, 6'b110000);
    end
    tick();
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b000001) begin
      n_fail++;
      $display("FAIL expiry_lock_priority: got %b expected %b", obs, 6'b000001);
    end
    rs_if.clk_locked = 1'b1;
  endtask

  task automatic test_lock_and_req();
    logic [5:0] obs;
    bring_up();
    rs_if.clk_locked = 1'b0;
    tick();
    tick();
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b111100) begin
      n_fail++;
      $display("FAIL lock_req_before: got %b expected %b", obs, 6'b111100);
    end
    rs_if.sysresetreq = 1'b1;
    tick();
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b000001) begin
      n_fail++;
      $display("FAIL lock_req_priority: got %b expected %b", obs, 6'b000001);
    end
    rs_if.sysresetreq = 1'b0;
    rs_if.clk_locked  = 1'b1;
  endtask

  task automatic test_ext_reset_sw_hold();
    logic [5:0] obs;
    bring_up();
    rs_if.sysresetreq = 1'b1;
    tick();
    rs_if.sysresetreq = 1'b0;
    tick();
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b100010) begin
      n_fail++;
      $display("FAIL sw_hold_state: got %b expected %b", obs, 6'b100010);
    end
    ext_reset_n = 1'b0;
    tick();
    obs = obs_vec();
    n_checks++;
    if (obs !== 6'b000000) begin
      n_fail++;
      $display("FAIL ext_reset_in_sw_hold: got %b expected %b", obs, 6'b000000);
    end
    ext_reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic bus, per, cpu, done;
    apply_reset();
    ext_reset_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rs_if.clk_locked  = ($urandom_range(0, 15) != 0);
      rs_if.sysresetreq = ($urandom_range(0, 7) == 0);
      ext_reset_n       = ($urandom_range(0, 63) != 0);
      tick();
      bus  = rs_if.bus_reset_n;
      per  = rs_if.periph_reset_n;
      cpu  = rs_if.cpu_reset_n;
      done = rs_if.seq_done;
      n_checks++;
      if ((cpu && !per) || (per && !bus) || (done !== cpu)) begin
        n_fail++;
        $display("FAIL monotonic cycle %0d: got bus=%b periph=%b cpu=%b done=%b required ordered release",
                 i, bus, per, cpu, done);
      end
    end
    ext_reset_n       = 1'b1;
    rs_if.sysresetreq = 1'b0;
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    ext_reset_n       = 1'b0;
    rs_if.clk_locked  = 1'b0;
    rs_if.sysresetreq = 1'b0;
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_sw_pulse();
    test_sw_held();
    test_lock_loss_periph();
    test_lock_loss_expiry();
    test_lock_and_req();
    test_ext_reset_sw_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
